// File: rtl/sparc_cu_pkg.sv
// Shared definitions for the SPARC-subset front end: control-vector bit
// positions, ALU opcodes, instruction field encodings, next-PC source
// selects and memory access size codes.
package sparc_cu_pkg;

  // Control vector layout
  localparam int CS_WIDTH       = 19;
  localparam int CS_CALL        = 0;
  localparam int CS_JMPL        = 1;
  localparam int CS_LOAD        = 2;
  localparam int CS_RF_WE       = 3;
  localparam int CS_MEM_SE      = 4;
  localparam int CS_MEM_RW      = 5;
  localparam int CS_MEM_EN      = 6;
  localparam int CS_MEM_SIZE_LO = 7;
  localparam int CS_MEM_SIZE_HI = 8;
  localparam int CS_CC_EN       = 9;
  localparam int CS_I31         = 10;
  localparam int CS_I30         = 11;
  localparam int CS_I24         = 12;
  localparam int CS_I13         = 13;
  localparam int CS_ALU_LO      = 14;
  localparam int CS_ALU_HI      = 17;
  localparam int CS_BRANCH      = 18;

  // ALU opcodes (subx and sra share 1100; execute separates them with I24)
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_AND   = 4'b0001;
  localparam logic [3:0] ALU_OR    = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_ANDN  = 4'b0101;
  localparam logic [3:0] ALU_ORN   = 4'b0110;
  localparam logic [3:0] ALU_XNOR  = 4'b0111;
  localparam logic [3:0] ALU_ADDX  = 4'b1000;
  localparam logic [3:0] ALU_SUBX  = 4'b1100;
  localparam logic [3:0] ALU_SLL   = 4'b1010;
  localparam logic [3:0] ALU_SRL   = 4'b1011;
  localparam logic [3:0] ALU_SRA   = 4'b1100;
  localparam logic [3:0] ALU_PASSB = 4'b1101;

  // Instruction format selector (instr[31:30])
  typedef enum logic [1:0] {
    OP_FMT2  = 2'b00,
    OP_CALL  = 2'b01,
    OP_ARITH = 2'b10,
    OP_MEM   = 2'b11
  } op_e;

  // op2 (instr[24:22]) for format-2 instructions
  localparam logic [2:0] OP2_BICC  = 3'b010;
  localparam logic [2:0] OP2_SETHI = 3'b100;

  // op3 (instr[24:19]) for format-3 arithmetic instructions
  localparam logic [5:0] OP3_SLL  = 6'b100101;
  localparam logic [5:0] OP3_SRL  = 6'b100110;
  localparam logic [5:0] OP3_SRA  = 6'b100111;
  localparam logic [5:0] OP3_JMPL = 6'b111000;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_SEL_NPC  = 2'b00,
    PC_SEL_TA   = 2'b01,
    PC_SEL_ALU  = 2'b10,
    PC_SEL_HOLD = 2'b11
  } pc_sel_e;

  // Memory access size codes carried in the control vector
  localparam logic [1:0] MEM_SIZE_BYTE   = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF   = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD   = 2'b10;
  localparam logic [1:0] MEM_SIZE_DOUBLE = 2'b11;

  // Map the size bits of a load/store op3 onto the control-vector size code
  function automatic logic [1:0] mem_size_code(input logic [1:0] op3_lo);
    logic [1:0] code;
    case (op3_lo)
      2'b01:   code = MEM_SIZE_BYTE;
      2'b10:   code = MEM_SIZE_HALF;
      2'b00:   code = MEM_SIZE_WORD;
      default: code = MEM_SIZE_DOUBLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pc_npc_register.sv
// Fetch PC register with its 4-way next-PC source mux and the +4 adder
// that produces nPC. Asynchronous active-low reset loads RESET_PC.
module pc_npc_register
  import sparc_cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        le,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] ta,
  input  logic [31:0] alu_out,
  output logic [31:0] pc,
  output logic [31:0] npc
);

  logic [31:0] r_pc;
  logic [31:0] w_npc;
  logic [31:0] w_pc_next;

  // nPC wraps naturally modulo 2^32
  assign w_npc = r_pc + 32'd4;

  // Select the value the PC takes on the next enabled edge
  always_comb begin
    w_pc_next = r_pc;
    case (pc_sel_e'(pc_sel))
      PC_SEL_NPC:  w_pc_next = w_npc;
      PC_SEL_TA:   w_pc_next = ta;
      PC_SEL_ALU:  w_pc_next = alu_out;
      PC_SEL_HOLD: w_pc_next = r_pc;
      default:     w_pc_next = r_pc;
    endcase
  end

  // PC state: reset wins over any clock edge, otherwise load when enabled
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pc <= RESET_PC;
    end else if (le) begin
      r_pc <= w_pc_next;
    end
  end

  assign pc  = r_pc;
  assign npc = w_npc;

endmodule

// File: rtl/control_unit.sv
// Front end of the 5-stage SPARC-subset pipeline: fetch PC / nPC and the
// instruction decoder producing the 19-bit control vector.
// Build option: define CU_REGISTERED_OUTPUT_EN to register the control
// vector (one cycle of latency, async clear on clr=0); by default it is
// purely combinational and forced to zero while clr=0.
module control_unit
  import sparc_cu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        le,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] ta,
  input  logic [31:0] alu_out,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [18:0] instr_signals
);

  logic [1:0]          w_op;
  logic [2:0]          w_op2;
  logic [5:0]          w_op3;
  logic [CS_WIDTH-1:0] w_decoded;

  assign w_op  = instr[31:30];
  assign w_op2 = instr[24:22];
  assign w_op3 = instr[24:19];

  pc_npc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_npc (
    .clk     (clk),
    .clr     (clr),
    .le      (le),
    .pc_sel  (pc_sel),
    .ta      (ta),
    .alu_out (alu_out),
    .pc      (pc),
    .npc     (npc)
  );

  // Decode the instruction into the control vector; unrecognised
  // encodings leave everything but the raw instruction bits at zero
  always_comb begin
    w_decoded          = '0;
    w_decoded[CS_I31]  = instr[31];
    w_decoded[CS_I30]  = instr[30];
    w_decoded[CS_I24]  = instr[24];
    w_decoded[CS_I13]  = instr[13];
    case (op_e'(w_op))
      OP_CALL: begin
        w_decoded[CS_CALL]             = 1'b1;
        w_decoded[CS_RF_WE]            = 1'b1;
        w_decoded[CS_ALU_HI:CS_ALU_LO] = ALU_ADD;
      end
      OP_FMT2: begin
        // An all-zero word is the NOP and must produce no control at all
        if (instr != 32'd0) begin
          if (w_op2 == OP2_SETHI) begin
            w_decoded[CS_RF_WE]            = 1'b1;
            w_decoded[CS_ALU_HI:CS_ALU_LO] = ALU_PASSB;
          end else if (w_op2 == OP2_BICC) begin
            w_decoded[CS_BRANCH] = 1'b1;
          end
        end
      end
      OP_ARITH: begin
        if (w_op3 == OP3_JMPL) begin
          w_decoded[CS_JMPL]             = 1'b1;
          w_decoded[CS_RF_WE]            = 1'b1;
          w_decoded[CS_ALU_HI:CS_ALU_LO] = ALU_ADD;
        end else if (!w_op3[5]) begin
          // Plain ALU ops: low op3 bits are the ALU code, op3[4] sets CCs
          w_decoded[CS_RF_WE]            = 1'b1;
          w_decoded[CS_CC_EN]            = w_op3[4];
          w_decoded[CS_ALU_HI:CS_ALU_LO] = w_op3[3:0];
        end else if (w_op3 == OP3_SLL) begin
          w_decoded[CS_RF_WE]            = 1'b1;
          w_decoded[CS_ALU_HI:CS_ALU_LO] = ALU_SLL;
        end else if (w_op3 == OP3_SRL) begin
          w_decoded[CS_RF_WE]            = 1'b1;
          w_decoded[CS_ALU_HI:CS_ALU_LO] = ALU_SRL;
        end else if (w_op3 == OP3_SRA) begin
          w_decoded[CS_RF_WE]            = 1'b1;
          w_decoded[CS_ALU_HI:CS_ALU_LO] = ALU_SRA;
        end
      end
      OP_MEM: begin
        // op3[2] distinguishes store from load, op3[3] selects sign-extend
        w_decoded[CS_MEM_EN]                     = 1'b1;
        w_decoded[CS_ALU_HI:CS_ALU_LO]           = ALU_ADD;
        w_decoded[CS_LOAD]                       = ~w_op3[2];
        w_decoded[CS_RF_WE]                      = ~w_op3[2];
        w_decoded[CS_MEM_RW]                     = w_op3[2];
        w_decoded[CS_MEM_SE]                     = w_op3[3];
        w_decoded[CS_MEM_SIZE_HI:CS_MEM_SIZE_LO] = mem_size_code(w_op3[1:0]);
      end
      default: w_decoded = w_decoded;
    endcase
  end

`ifdef CU_REGISTERED_OUTPUT_EN
  logic [CS_WIDTH-1:0] r_instr_signals;

  // Registered control vector, cleared asynchronously by reset
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_instr_signals <= '0;
    end else begin
      r_instr_signals <= w_decoded;
    end
  end

  assign instr_signals = r_instr_signals;
`else
  // Reset masks the decoder output immediately, whatever instr holds
  assign instr_signals = clr ? w_decoded : '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: PC sequencing against a simple
// arithmetic PC model and decode against a rule-based reference decoder.
module tb_control_unit;

  logic        clk;
  logic        clr;
  logic        le;
  logic [1:0]  pc_sel;
  logic [31:0] ta;
  logic [31:0] alu_out;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [18:0] instr_signals;

  int n_checks;
  int n_errors;
  logic [31:0] m_pc;

  control_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .clr           (clr),
    .le            (le),
    .pc_sel        (pc_sel),
    .ta            (ta),
    .alu_out       (alu_out),
    .instr         (instr),
    .pc            (pc),
    .npc           (npc),
    .instr_signals (instr_signals)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference models ----------------

  // Control vector built from the instruction-set rules as a weighted sum
  function automatic logic [18:0] ref_decode(input logic [31:0] i);
    int op, op2, op3, lo;
    int call, jmpl, load, rf, se, rw, men, size, cc, alu, br;
    int sum;
    op  = int'(i[31:30]);
    op2 = int'(i[24:22]);
    op3 = int'(i[24:19]);
    call = 0; jmpl = 0; load = 0; rf = 0; se = 0; rw = 0; men = 0;
    size = 0; cc = 0; alu = 0; br = 0;
    if (op == 1) begin
      call = 1; rf = 1; alu = 0;
    end else if (op == 0) begin
      if (i != 0 && op2 == 4) begin rf = 1; alu = 13; end
      else if (i != 0 && op2 == 2) br = 1;
    end else if (op == 2) begin
      if (op3 == 56) begin jmpl = 1; rf = 1; alu = 0; end
      else if (op3 < 32) begin rf = 1; alu = op3 % 16; cc = (op3 / 16) % 2; end
      else if (op3 == 37) begin rf = 1; alu = 10; end
      else if (op3 == 38) begin rf = 1; alu = 11; end
      else if (op3 == 39) begin rf = 1; alu = 12; end
    end else begin
      men  = 1;
      alu  = 0;
      rw   = (op3 / 4) % 2;
      load = 1 - rw;
      rf   = 1 - rw;
      se   = (op3 / 8) % 2;
      lo   = op3 % 4;
      size = (lo == 1) ? 0 : (lo == 2) ? 1 : (lo == 0) ? 2 : 3;
    end
    sum = call + 2 * jmpl + 4 * load + 8 * rf + 16 * se + 32 * rw + 64 * men
        + 128 * size + 512 * cc
        + 1024 * int'(i[31]) + 2048 * int'(i[30])
        + 4096 * int'(i[24]) + 8192 * int'(i[13])
        + 16384 * alu + 262144 * br;
    return 19'(sum);
  endfunction

  // Expected PC after one enabled or disabled edge
  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur, input logic en,
                                               input logic [1:0] sel, input logic [31:0] t,
                                               input logic [31:0] a);
    if (!en) return cur;
    if (sel == 2'd0) return cur + 32'd4;
    if (sel == 2'd1) return t;
    if (sel == 2'd2) return a;
    return cur;
  endfunction

  // ---------------- driver tasks ----------------

  // One clock edge, updating the PC model, then sample 1 time unit later
  task automatic tick();
    m_pc = ref_next_pc(m_pc, le, pc_sel, ta, alu_out);
    @(posedge clk);
    #1;
  endtask

  // Let the decode output reflect the current instr (one edge when registered)
  task automatic settle_decode();
`ifdef CU_REGISTERED_OUTPUT_EN
    le = 1'b0;
    tick();
`else
    #1;
`endif
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    clr = 1'b0; le = 1'b1; pc_sel = 2'b00; ta = '0; alu_out = '0;
    instr = 32'hC600_4002;
    m_pc = 32'h0;
    #2;
    n_checks++;
    if (pc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_pc: got %h expected %h", pc, 32'h0);
    end
    n_checks++;
    if (instr_signals !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_signals: got %h expected %h", instr_signals, 19'h0);
    end
    // Clock edges during reset must not move the PC
    @(posedge clk); #1;
    n_checks++;
    if (pc !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_edge_pc: got %h expected %h", pc, 32'h0);
    end
    clr = 1'b1;
  endtask

  task automatic test_pc_sequence();
    logic [31:0] exp_pc[$];
    exp_pc = '{32'd4, 32'd8, 32'd12};
    le = 1'b1; pc_sel = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (pc !== exp_pc[k] || pc !== m_pc) begin
        n_errors++;
        $display("FAIL pc_seq%0d: got %h expected %h", k, pc, exp_pc[k]);
      end
    end
    n_checks++;
    if (npc !== 32'd16) begin
      n_errors++;
      $display("FAIL npc_seq: got %h expected %h", npc, 32'd16);
    end
  endtask

  task automatic test_pc_sources();
    le = 1'b1; pc_sel = 2'b01; ta = 32'h40;
    tick();
    n_checks++;
    if (pc !== 32'h40) begin
      n_errors++;
      $display("FAIL pc_ta: got %h expected %h", pc, 32'h40);
    end
    pc_sel = 2'b10; alu_out = 32'h80;
    tick();
    n_checks++;
    if (pc !== 32'h80) begin
      n_errors++;
      $display("FAIL pc_alu: got %h expected %h", pc, 32'h80);
    end
    le = 1'b0; pc_sel = 2'b00;
    tick(); tick();
    n_checks++;
    if (pc !== 32'h80) begin
      n_errors++;
      $display("FAIL pc_le0: got %h expected %h", pc, 32'h80);
    end
    le = 1'b1; pc_sel = 2'b11;
    tick(); tick();
    n_checks++;
    if (pc !== 32'h80) begin
      n_errors++;
      $display("FAIL pc_hold: got %h expected %h", pc, 32'h80);
    end
  endtask

  task automatic test_npc_wrap();
    le = 1'b1; pc_sel = 2'b01; ta = 32'hFFFF_FFFC;
    tick();
    n_checks++;
    if (npc !== 32'h0) begin
      n_errors++;
      $display("FAIL npc_wrap: got %h expected %h", npc, 32'h0);
    end
    pc_sel = 2'b00;
    tick();
    n_checks++;
    if (pc !== 32'h0) begin
      n_errors++;
      $display("FAIL pc_wrap: got %h expected %h", pc, 32'h0);
    end
  endtask

  task automatic test_decode_vectors();
    logic [31:0] vin[$];
    logic [18:0] vexp[$];
    vin  = '{32'hC600_4002, 32'h4000_0004, 32'h0000_0000, 32'h8680_4002, 32'h0280_0004};
    vexp = '{19'h00D4C,     19'h00809,     19'h00000,     19'h00608,     19'h40000};
    le = 1'b0;
    for (int k = 0; k < vin.size(); k++) begin
      instr = vin[k];
      settle_decode();
      n_checks++;
      if (instr_signals !== vexp[k] || vexp[k] !== ref_decode(vin[k])) begin
        n_errors++;
        $display("FAIL decode_vec%0d: instr %h got %h expected %h",
                 k, vin[k], instr_signals, vexp[k]);
      end
    end
  endtask

  task automatic test_decode_random();
    logic [31:0] r;
    logic [18:0] e;
    logic [5:0]  specials[$];
    specials = '{6'b111000, 6'b100101, 6'b100110, 6'b100111};
    le = 1'b0;
    for (int k = 0; k < 200; k++) begin
      r = $urandom;
      case ($urandom_range(0, 6))
        0: r[31:30] = 2'b11;
        1: begin r[31:30] = 2'b10; r[24:19] = specials[$urandom_range(0, 3)]; end
        2: begin r[31:30] = 2'b10; r[24] = 1'b0; end
        3: r[31:30] = 2'b00;
        4: r[31:30] = 2'b01;
        5: r = 32'h0;
        default: ;
      endcase
      instr = r;
      e = ref_decode(r);
      settle_decode();
      n_checks++;
      if (instr_signals !== e) begin
        n_errors++;
        $display("FAIL decode_rand%0d: instr %h got %h expected %h", k, r, instr_signals, e);
      end
    end
  endtask

  task automatic test_pc_random();
    for (int k = 0; k < 100; k++) begin
      le      = 1'($urandom_range(0, 1));
      pc_sel  = 2'($urandom_range(0, 3));
      ta      = $urandom & 32'hFFFF_FFFC;
      alu_out = $urandom & 32'hFFFF_FFFC;
      instr   = $urandom;
      tick();
      n_checks++;
      if (pc !== m_pc || npc !== m_pc + 32'd4) begin
        n_errors++;
        $display("FAIL pc_rand%0d: got pc %h npc %h expected pc %h npc %h",
                 k, pc, npc, m_pc, m_pc + 32'd4);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    le = 1'b1; pc_sel = 2'b01; ta = 32'h0000_1230;
    instr = 32'hC600_4002;
    tick();
    #2;
    clr = 1'b0;
    #1;
    n_checks++;
    if (pc !== 32'h0) begin
      n_errors++;
      $display("FAIL midreset_pc: got %h expected %h", pc, 32'h0);
    end
    n_checks++;
    if (instr_signals !== 19'h0) begin
      n_errors++;
      $display("FAIL midreset_signals: got %h expected %h", instr_signals, 19'h0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (pc !== 32'h0 || instr_signals !== 19'h0) begin
      n_errors++;
      $display("FAIL midreset_hold: got pc %h sig %h expected 0 0", pc, instr_signals);
    end
    m_pc = 32'h0;
    clr = 1'b1;
    pc_sel = 2'b00;
    tick();
    n_checks++;
    if (pc !== 32'h4) begin
      n_errors++;
      $display("FAIL midreset_resume: got %h expected %h", pc, 32'h4);
    end
  endtask

  // ---------------- sequence and report ----------------

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_pc_sequence();
    test_pc_sources();
    test_npc_wrap();
    test_decode_vectors();
    test_decode_random();
    test_pc_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
